// File: rtl/icache_ctrl.sv
// Miss/prefetch controller for the direct-mapped instruction cache: streams
// sequential line loads after a miss and writes returning lines into the cache.
module icache_ctrl #(
   parameter int PF_DEPTH = 8,
   parameter int MAX_OUT  = 4,
   parameter int TAG_W    = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             fetch_miss,
   input  logic [63:0]      fetch_addr,
   output logic [1:0]       mem_command,
   output logic [63:0]      mem_addr,
   input  logic [3:0]       mem_response,
   input  logic [3:0]       mem_tag,
   input  logic [63:0]      mem_data,
   output logic [4:0]       pf_idx,
   output logic [TAG_W-1:0] pf_tag,
   input  logic             pf_in_cache,
   output logic             wr_en,
   output logic [4:0]       wr_idx,
   output logic [TAG_W-1:0] wr_tag,
   output logic [63:0]      wr_data,
   output logic             busy
);
   localparam int CNT_W = $clog2(PF_DEPTH + 1);
   localparam int KEY_W = 5 + TAG_W;

   typedef enum logic { IDLE, STREAM } state_t;
   typedef struct packed {
      logic             valid;
      logic [3:0]       mtag;
      logic [4:0]       idx;
      logic [TAG_W-1:0] tag;
   } entry_t;

   state_t                 state;
   entry_t [MAX_OUT-1:0]   tbl;
   logic [60:0]            ptr;
   logic [CNT_W-1:0]       count;

   logic [60:0]            miss_line;
   logic                   streaming, ptr_hit, miss_hit, skip;
   logic                   issue, accept, advance, redirect;
   logic [MAX_OUT-1:0]     valid_v, freed, avail, alloc_oh;
   logic                   unused_addr_bits;

   assign miss_line        = fetch_addr[63:3];
   assign unused_addr_bits = ^fetch_addr[2:0];
   assign streaming        = (state == STREAM);

   // Table entries are matched on the cache key (idx, tag) only, not the full line.
   always_comb begin
      ptr_hit  = 1'b0;
      miss_hit = 1'b0;
      valid_v  = '0;
      freed    = '0;
      for (int i = 0; i < MAX_OUT; i++) begin
         valid_v[i] = tbl[i].valid;
         freed[i]   = tbl[i].valid && (mem_tag != 4'd0) && (tbl[i].mtag == mem_tag);
         if (tbl[i].valid && ({tbl[i].tag, tbl[i].idx} == ptr[KEY_W-1:0]))
            ptr_hit = 1'b1;
         if (tbl[i].valid && ({tbl[i].tag, tbl[i].idx} == miss_line[KEY_W-1:0]))
            miss_hit = 1'b1;
      end
   end

   // An entry returning this cycle counts as free, so a full table can still issue.
   assign avail    = ~valid_v | freed;
   assign alloc_oh = avail & (~avail + MAX_OUT'(1));
   assign skip     = pf_in_cache || ptr_hit;
   assign issue    = streaming && !skip && (|avail);
   assign accept   = issue && (mem_response != 4'd0);
   assign advance  = streaming && (skip || accept);
   assign redirect = streaming && fetch_miss && (miss_line != ptr) && !miss_hit;

   assign mem_command = issue ? 2'b01 : 2'b00;
   assign mem_addr    = issue ? {ptr, 3'b000} : 64'd0;
   assign pf_idx      = ptr[4:0];
   assign pf_tag      = ptr[5 +: TAG_W];
   assign busy        = streaming || (|valid_v);

   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = '0;
      wr_tag  = '0;
      wr_data = '0;
      for (int i = 0; i < MAX_OUT; i++) begin
         if (freed[i]) begin
            wr_en   = 1'b1;
            wr_idx  = tbl[i].idx;
            wr_tag  = tbl[i].tag;
            wr_data = mem_data;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         tbl   <= '0;
         ptr   <= '0;
         count <= '0;
      end else begin
         for (int i = 0; i < MAX_OUT; i++) begin
            if (accept && alloc_oh[i])
               tbl[i] <= '{valid: 1'b1, mtag: mem_response, idx: ptr[4:0], tag: ptr[5 +: TAG_W]};
            else if (freed[i])
               tbl[i].valid <= 1'b0;
         end
         if (!streaming) begin
            if (fetch_miss) begin
               state <= STREAM;
               ptr   <= miss_line;
               count <= '0;
            end
         end else if (redirect) begin
            ptr   <= miss_line;
            count <= '0;
         end else if (advance) begin
            ptr   <= ptr + 61'd1;
            count <= count + CNT_W'(1);
            if (count == CNT_W'(PF_DEPTH - 1))
               state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: directed scenarios plus random traffic against a
// tag-keyed behavioural model of the stream and outstanding loads.
module tb_icache_ctrl;
   localparam int PF_DEPTH = 8;
   localparam int MAX_OUT  = 4;
   localparam int TAG_W    = 8;

   logic             clock = 1'b0;
   logic             reset;
   logic             fetch_miss;
   logic [63:0]      fetch_addr;
   logic [1:0]       mem_command;
   logic [63:0]      mem_addr;
   logic [3:0]       mem_response;
   logic [3:0]       mem_tag;
   logic [63:0]      mem_data;
   logic [4:0]       pf_idx;
   logic [TAG_W-1:0] pf_tag;
   logic             pf_in_cache;
   logic             wr_en;
   logic [4:0]       wr_idx;
   logic [TAG_W-1:0] wr_tag;
   logic [63:0]      wr_data;
   logic             busy;

   int errors = 0;
   int checks = 0;

   icache_ctrl #(.PF_DEPTH(PF_DEPTH), .MAX_OUT(MAX_OUT), .TAG_W(TAG_W)) dut (
      .clock(clock), .reset(reset), .fetch_miss(fetch_miss), .fetch_addr(fetch_addr),
      .mem_command(mem_command), .mem_addr(mem_addr), .mem_response(mem_response),
      .mem_tag(mem_tag), .mem_data(mem_data), .pf_idx(pf_idx), .pf_tag(pf_tag),
      .pf_in_cache(pf_in_cache), .wr_en(wr_en), .wr_idx(wr_idx), .wr_tag(wr_tag),
      .wr_data(wr_data), .busy(busy)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      @(negedge clock);
   endtask

   task automatic clear_inputs();
      fetch_miss   = 1'b0;
      fetch_addr   = 64'd0;
      mem_response = 4'd0;
      mem_tag      = 4'd0;
      mem_data     = 64'd0;
      pf_in_cache  = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic start_miss(input logic [63:0] a);
      fetch_miss = 1'b1;
      fetch_addr = a;
      tick();
      fetch_miss = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      settle();
      checks++; if (mem_command !== 2'b00) begin errors++; $display("FAIL rst_cmd got=%0h exp=0", mem_command); end
      checks++; if (mem_addr !== 64'd0) begin errors++; $display("FAIL rst_addr got=%0h exp=0", mem_addr); end
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got=%0b exp=0", wr_en); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b exp=0", busy); end
      tick();
   endtask

   task automatic test_cold_miss();
      int rt[3] = '{1, 3, 4};
      do_reset();
      fetch_miss = 1'b1;
      fetch_addr = 64'h1000;
      settle();
      checks++; if (mem_command !== 2'b00) begin errors++; $display("FAIL cold_idle_cmd got=%0h exp=0", mem_command); end
      tick();
      fetch_miss = 1'b0;
      for (int k = 0; k < 4; k++) begin
         mem_response = 4'(k + 1);
         settle();
         checks++; if (mem_command !== 2'b01 || mem_addr !== 64'h1000 + 64'(8 * k)) begin
            errors++; $display("FAIL cold_load%0d got=%0h/%0h exp=1/%0h", k, mem_command, mem_addr, 64'h1000 + 64'(8 * k)); end
         tick();
      end
      mem_response = 4'd9;
      for (int k = 0; k < 2; k++) begin
         settle();
         checks++; if (mem_command !== 2'b00 || busy !== 1'b1) begin
            errors++; $display("FAIL cold_full_stall%0d got cmd=%0h busy=%0b exp cmd=0 busy=1", k, mem_command, busy); end
         tick();
      end
      mem_tag      = 4'd2;
      mem_data     = 64'hDEADBEEF;
      mem_response = 4'd5;
      settle();
      checks++; if (wr_en !== 1'b1 || wr_idx !== 5'd1 || wr_tag !== 8'h10 || wr_data !== 64'hDEADBEEF) begin
         errors++; $display("FAIL cold_ret2 got en=%0b idx=%0h tag=%0h data=%0h exp 1/1/10/deadbeef", wr_en, wr_idx, wr_tag, wr_data); end
      checks++; if (mem_command !== 2'b01 || mem_addr !== 64'h1020) begin
         errors++; $display("FAIL cold_refill got=%0h/%0h exp=1/1020", mem_command, mem_addr); end
      tick();
      for (int j = 0; j < 3; j++) begin
         mem_tag      = 4'(rt[j]);
         mem_response = 4'(6 + j);
         mem_data     = 64'(j);
         settle();
         checks++; if (wr_en !== 1'b1 || mem_command !== 2'b01 || mem_addr !== 64'h1028 + 64'(8 * j)) begin
            errors++; $display("FAIL cold_swap%0d got en=%0b cmd=%0h addr=%0h exp 1/1/%0h", j, wr_en, mem_command, mem_addr, 64'h1028 + 64'(8 * j)); end
         tick();
      end
      mem_tag      = 4'd0;
      mem_response = 4'd0;
      settle();
      checks++; if (mem_command !== 2'b00 || busy !== 1'b1) begin
         errors++; $display("FAIL cold_done got cmd=%0h busy=%0b exp 0/1", mem_command, busy); end
      tick();
      for (int t = 5; t <= 8; t++) begin
         mem_tag = 4'(t);
         tick();
      end
      mem_tag = 4'd0;
      settle();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cold_drain_busy got=%0b exp=0", busy); end
      tick();
   endtask

   task automatic test_probe_hits();
      int loads = 0;
      logic [3:0] prev = 4'd0;
      logic [3:0] nt = 4'd1;
      logic hit;
      do_reset();
      start_miss(64'h1000);
      for (int k = 0; k < 8; k++) begin
         hit          = (k == 1 || k == 2);
         pf_in_cache  = hit;
         mem_tag      = prev;
         mem_response = hit ? 4'd0 : nt;
         settle();
         checks++; if (pf_idx !== 5'(k) || pf_tag !== 8'h10) begin
            errors++; $display("FAIL probe_ptr%0d got=%0h/%0h exp=%0h/10", k, pf_idx, pf_tag, k); end
         checks++; if (mem_command !== (hit ? 2'b00 : 2'b01)) begin
            errors++; $display("FAIL probe_cmd%0d got=%0h exp=%0h", k, mem_command, hit ? 2'b00 : 2'b01); end
         if (mem_command == 2'b01) loads++;
         tick();
         prev = hit ? 4'd0 : nt;
         if (!hit) nt = nt + 4'd1;
      end
      pf_in_cache  = 1'b0;
      mem_tag      = prev;
      mem_response = 4'd0;
      settle();
      checks++; if (mem_command !== 2'b00) begin errors++; $display("FAIL probe_idle_cmd got=%0h exp=0", mem_command); end
      checks++; if (loads !== 6) begin errors++; $display("FAIL probe_loads got=%0d exp=6", loads); end
      tick();
      mem_tag = 4'd0;
      settle();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL probe_busy got=%0b exp=0", busy); end
      tick();
   endtask

   task automatic test_retry();
      do_reset();
      start_miss(64'h2000);
      mem_response = 4'd0;
      for (int k = 0; k < 3; k++) begin
         settle();
         checks++; if (mem_command !== 2'b01 || mem_addr !== 64'h2000) begin
            errors++; $display("FAIL retry%0d got=%0h/%0h exp=1/2000", k, mem_command, mem_addr); end
         tick();
      end
      mem_response = 4'd5;
      settle();
      checks++; if (mem_addr !== 64'h2000) begin errors++; $display("FAIL retry_accept got=%0h exp=2000", mem_addr); end
      tick();
      mem_response = 4'd0;
      settle();
      checks++; if (mem_command !== 2'b01 || mem_addr !== 64'h2008) begin
         errors++; $display("FAIL retry_next got=%0h/%0h exp=1/2008", mem_command, mem_addr); end
      tick();
   endtask

   task automatic test_redirect();
      do_reset();
      start_miss(64'h1000);
      mem_response = 4'd1; tick();
      mem_response = 4'd2; tick();
      mem_response = 4'd0;
      fetch_miss   = 1'b1;
      fetch_addr   = 64'h4000;
      settle();
      checks++; if (mem_command !== 2'b01 || mem_addr !== 64'h1010) begin
         errors++; $display("FAIL redir_cycle got=%0h/%0h exp=1/1010", mem_command, mem_addr); end
      tick();
      fetch_miss   = 1'b0;
      mem_response = 4'd3;
      settle();
      checks++; if (mem_command !== 2'b01 || mem_addr !== 64'h4000) begin
         errors++; $display("FAIL redir_new got=%0h/%0h exp=1/4000", mem_command, mem_addr); end
      tick();
      fetch_miss   = 1'b1;
      fetch_addr   = 64'h1008;
      mem_response = 4'd4;
      settle();
      checks++; if (mem_addr !== 64'h4008) begin errors++; $display("FAIL redir_ign_a got=%0h exp=4008", mem_addr); end
      tick();
      fetch_miss   = 1'b0;
      mem_response = 4'd0;
      mem_tag      = 4'd1;
      mem_data     = 64'h1111;
      settle();
      checks++; if (mem_addr !== 64'h4010) begin errors++; $display("FAIL redir_ign_b got=%0h exp=4010", mem_addr); end
      checks++; if (wr_en !== 1'b1 || wr_idx !== 5'd0 || wr_tag !== 8'h10 || wr_data !== 64'h1111) begin
         errors++; $display("FAIL redir_old1 got en=%0b idx=%0h tag=%0h exp 1/0/10", wr_en, wr_idx, wr_tag); end
      tick();
      mem_tag = 4'd2;
      settle();
      checks++; if (wr_en !== 1'b1 || wr_idx !== 5'd1 || wr_tag !== 8'h10) begin
         errors++; $display("FAIL redir_old2 got en=%0b idx=%0h tag=%0h exp 1/1/10", wr_en, wr_idx, wr_tag); end
      tick();
      mem_tag = 4'd0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      start_miss(64'h1000);
      mem_response = 4'd1; tick();
      mem_response = 4'd2; tick();
      mem_response = 4'd3; tick();
      mem_response = 4'd0;
      reset = 1'b1;
      tick();
      reset   = 1'b0;
      mem_tag = 4'd3;
      settle();
      checks++; if (wr_en !== 1'b0 || busy !== 1'b0 || mem_command !== 2'b00) begin
         errors++; $display("FAIL rstmid got en=%0b busy=%0b cmd=%0h exp 0/0/0", wr_en, busy, mem_command); end
      tick();
      mem_tag = 4'd0;
   endtask

   task automatic test_random();
      logic [60:0] out[int];
      logic [60:0] m_ptr = '0;
      bit          m_stream = 1'b0;
      int          m_cnt = 0;
      logic [63:0] bases[4] = '{64'h1000, 64'h1040, 64'h2000, 64'hFFFF_FFFF_FFFF_FFC0};
      int          keys[$];
      int          t, r;
      bit          ret, ptr_alias, miss_alias, skip, cap, e_cmd, accept, adv, redir;
      logic [63:0] e_addr;
      logic [60:0] e_line, miss_line;
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         reset       = ($urandom_range(0, 199) == 0);
         fetch_miss  = ($urandom_range(0, 99) < 6);
         fetch_addr  = bases[$urandom_range(0, 3)] + 64'($urandom_range(0, 15) * 8) + 64'($urandom_range(0, 7));
         pf_in_cache = ($urandom_range(0, 3) == 0);
         mem_data    = {$urandom, $urandom};
         r = $urandom_range(0, 9);
         mem_tag = 4'd0;
         if (r < 4 && out.num() > 0) begin
            keys.delete();
            foreach (out[k]) keys.push_back(k);
            mem_tag = 4'(keys[$urandom_range(0, keys.size() - 1)]);
         end else if (r == 4) begin
            do t = $urandom_range(1, 15); while (out.exists(t));
            mem_tag = 4'(t);
         end
         mem_response = 4'd0;
         if ($urandom_range(0, 3) != 0) begin
            do t = $urandom_range(1, 15); while (out.exists(t) || t == int'(mem_tag));
            mem_response = 4'(t);
         end

         ret = (mem_tag != 4'd0) && out.exists(int'(mem_tag));
         ptr_alias = 1'b0;
         foreach (out[k]) if (out[k][12:0] == m_ptr[12:0]) ptr_alias = 1'b1;
         skip   = pf_in_cache || ptr_alias;
         cap    = (out.num() - (ret ? 1 : 0)) < MAX_OUT;
         e_cmd  = m_stream && !skip && cap;
         e_addr = e_cmd ? {m_ptr, 3'b000} : 64'd0;
         e_line = ret ? out[int'(mem_tag)] : '0;

         settle();
         if (!reset) begin
            checks++; if (mem_command !== (e_cmd ? 2'b01 : 2'b00) || mem_addr !== e_addr) begin
               errors++; $display("FAIL rnd_load c%0d got=%0h/%0h exp=%0b/%0h", cyc, mem_command, mem_addr, e_cmd, e_addr); end
            checks++; if (busy !== (m_stream || out.num() > 0)) begin
               errors++; $display("FAIL rnd_busy c%0d got=%0b exp=%0b", cyc, busy, m_stream || out.num() > 0); end
            checks++; if (wr_en !== ret) begin
               errors++; $display("FAIL rnd_wr_en c%0d got=%0b exp=%0b", cyc, wr_en, ret); end
            if (ret) begin
               checks++; if (wr_idx !== e_line[4:0] || wr_tag !== e_line[12:5] || wr_data !== mem_data) begin
                  errors++; $display("FAIL rnd_wr c%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", cyc, wr_idx, wr_tag, wr_data, e_line[4:0], e_line[12:5], mem_data); end
            end
            if (m_stream) begin
               checks++; if (pf_idx !== m_ptr[4:0] || pf_tag !== m_ptr[12:5]) begin
                  errors++; $display("FAIL rnd_probe c%0d got=%0h/%0h exp=%0h/%0h", cyc, pf_idx, pf_tag, m_ptr[4:0], m_ptr[12:5]); end
            end
         end
         tick();

         if (reset) begin
            out.delete();
            m_stream = 1'b0;
            m_ptr    = '0;
            m_cnt    = 0;
         end else begin
            miss_line  = fetch_addr[63:3];
            miss_alias = 1'b0;
            foreach (out[k]) if (out[k][12:0] == miss_line[12:0]) miss_alias = 1'b1;
            accept = e_cmd && (mem_response != 4'd0);
            adv    = m_stream && (skip || accept);
            redir  = m_stream && fetch_miss && (miss_line != m_ptr) && !miss_alias;
            if (ret) out.delete(int'(mem_tag));
            if (accept) out[int'(mem_response)] = m_ptr;
            if (!m_stream) begin
               if (fetch_miss) begin
                  m_stream = 1'b1;
                  m_ptr    = miss_line;
                  m_cnt    = 0;
               end
            end else if (redir) begin
               m_ptr = miss_line;
               m_cnt = 0;
            end else if (adv) begin
               m_ptr = m_ptr + 61'd1;
               m_cnt++;
               if (m_cnt == PF_DEPTH) m_stream = 1'b0;
            end
         end
      end
      reset = 1'b0;
      clear_inputs();
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_cold_miss();
      test_probe_hits();
      test_retry();
      test_redirect();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
Miss/prefetch controller for the 32-line, direct-mapped, even/odd-banked instruction cache. It takes miss requests from fetch, streams sequential line loads to instruction memory, tracks outstanding memory tags, and drives the cache write and prefetch-probe ports. It sits between fetch, the icache and the processor-to-memory port.

Parameters:
PF_DEPTH, 8, number of sequential lines fetched per miss stream, including the miss line
MAX_OUT, 4, entries in the outstanding-request table
TAG_W, 8, icache tag width in bits; the tag is addr[8+TAG_W-1:8]

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
fetch_miss  in  1  fetch missed the icache this cycle
fetch_addr  in  64  byte address of the missing fetch
mem_command  out  2  2'b00 = none, 2'b01 = load
mem_addr  out  64  line-aligned load address, addr[2:0] = 0
mem_response  in  4  nonzero = load accepted, with this tag; 0 = rejected
mem_tag  in  4  nonzero = data for this tag is on mem_data
mem_data  in  64  returned line
pf_idx  out  5  probe index to the icache, addr[7:3] of the prefetch pointer
pf_tag  out  TAG_W  probe tag to the icache
pf_in_cache  in  1  probed line is valid in the cache
wr_en  out  1  icache write enable
wr_idx  out  5  icache write full index
wr_tag  out  TAG_W  icache write tag
wr_data  out  64  icache write data
busy  out  1  stream active or any table entry valid

Behaviour:
- Reset: state IDLE, table cleared, pointer 0, count 0. Outputs: mem_command 0, mem_addr 0, wr_en 0, busy 0.
- A line address is addr[63:3]; index is addr[7:3]; tag is addr[8+TAG_W-1:8].
- FSM has two states, IDLE and STREAM.
- IDLE to STREAM on fetch_miss. The pointer loads fetch_addr line-aligned and count loads 0.
- In STREAM, each cycle pf_idx and pf_tag reflect the pointer.
  - If pf_in_cache is high, no load is issued. The pointer advances by 8 bytes and count increments.
  - Else if the table has a free entry or an entry freed this cycle: mem_command is load and mem_addr is the pointer. If mem_response is nonzero, allocate the lowest free entry {valid, mem_response, idx, tag}, advance the pointer and increment count. If mem_response is 0, retry the same address next cycle.
  - Else (table full): mem_command is none and the FSM stalls.
  - If the pointer already matches a valid table entry (same idx and tag), skip it as if pf_in_cache were high.
- STREAM to IDLE when count reaches PF_DEPTH after an advance.
- Redirect: fetch_miss in STREAM whose line matches neither the pointer nor a valid table entry restarts the stream at that line, with count 0, in the next cycle. An issue in the redirect cycle still proceeds.
  - A miss to the pointer line or an outstanding line is ignored.
  - Outstanding entries are never cancelled; their returns still write the cache.
- Returns: when mem_tag is nonzero and matches a valid entry's tag, in the same cycle (combinational):
  - wr_en is 1, wr_idx and wr_tag come from the entry, wr_data is mem_data.
  - The entry frees at the clock edge.
  - A nonzero mem_tag that matches no entry is ignored, with wr_en 0.
- Same-cycle allocate and free: a freed entry may be reallocated in the same cycle. Memory never reissues a live tag.
- Pointer wrap: addr[63:3] increments modulo 2^61.
- Reset mid-stream drops all entries. Data that returns later for a dropped tag is ignored.
- busy equals (state == STREAM) or (any table entry valid).

Test Plan:
- Cold miss at 0x1000, memory accepts every load with tags 1,2,3,4:
  - Loads go to 0x1000, 0x1008, 0x1010, 0x1018 on consecutive cycles.
  - The 5th load stalls (table full) until a return arrives.
  - After 8 issues the FSM returns to IDLE.
- Return of tag 2 with data 0xDEADBEEF: same cycle, wr_en=1, wr_idx=5'd1, wr_tag=8'h10, wr_data=0xDEADBEEF. The entry frees and the next load issues that cycle.
- Probe hits: pf_in_cache held high for lines 0x1008 and 0x1010 → no loads issued for them; count still reaches 8 with only 6 loads.
- mem_response=0 for 3 cycles at 0x2000 → mem_addr stays 0x2000; it is accepted on the 4th cycle, then the pointer moves to 0x2008.
- Redirect to 0x4000 mid-stream with 2 entries outstanding → the next load is 0x4000; the old returns still assert wr_en with their own idx and tag.
- Reset asserted with entries outstanding, then mem_tag=3 returns → wr_en stays 0, busy=0, mem_command=0.
